// File: rtl/regfile_pkg.sv
// Shared defaults and address type for the multi-port register file.
package regfile_pkg;
    localparam int DEF_DATA_W = 32;
    localparam int DEF_ADDR_W = 5;

    typedef logic [DEF_ADDR_W-1:0] reg_addr_t;
endpackage

// File: rtl/regfile_scoreboard.sv
// Pending-result scoreboard: one bit per register, set by a reservation and
// cleared when a write to that register commits.
module regfile_scoreboard
    import regfile_pkg::*;
#(
    parameter int ADDR_W   = DEF_ADDR_W,
    parameter int ZERO_REG = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rsv_en,
    input  logic [ADDR_W-1:0]    rsv_addr,
    input  logic [2**ADDR_W-1:0] clr_mask,
    output logic [2**ADDR_W-1:0] pending
);
    localparam int DEPTH   = 2**ADDR_W;
    localparam bit ZERO_EN = (ZERO_REG != 0);

    logic [DEPTH-1:0] pending_reg;
    logic [DEPTH-1:0] pending_next;
    logic [DEPTH-1:0] set_mask;

    // Set is applied after clear so a new producer outranks the finishing one.
    always_comb begin
        set_mask = '0;
        if (rsv_en && !(ZERO_EN && (rsv_addr == '0))) begin
            set_mask[rsv_addr] = 1'b1;
        end
        pending_next = (pending_reg & ~clr_mask) | set_mask;
        if (ZERO_EN) begin
            pending_next[0] = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pending_reg <= '0;
        end else begin
            pending_reg <= pending_next;
        end
    end

    assign pending = pending_reg;
endmodule

// File: rtl/regfile_mp.sv
// Multi-port register file with optional write-to-read bypass, hardwired
// zero register, write-collision flag and a per-register pending scoreboard.
module regfile_mp
    import regfile_pkg::*;
#(
    parameter int DATA_W   = DEF_DATA_W,
    parameter int ADDR_W   = DEF_ADDR_W,
    parameter int NRD      = 2,
    parameter int NWR      = 2,
    parameter int BYPASS   = 1,
    parameter int ZERO_REG = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NRD*ADDR_W-1:0] rd_addr,
    output logic [NRD*DATA_W-1:0] rd_data,
    output logic [NRD-1:0]        rd_busy,
    input  logic [NWR-1:0]        wr_en,
    input  logic [NWR*ADDR_W-1:0] wr_addr,
    input  logic [NWR*DATA_W-1:0] wr_data,
    input  logic                  rsv_en,
    input  logic [ADDR_W-1:0]     rsv_addr,
    output logic                  wr_collide
);
    localparam int DEPTH   = 2**ADDR_W;
    localparam bit ZERO_EN = (ZERO_REG != 0);
    localparam bit BYP_EN  = (BYPASS != 0);

    logic [DATA_W-1:0] regs_reg [DEPTH];
    logic [DEPTH-1:0]  pending;
    logic [DEPTH-1:0]  clr_mask;
    logic              collide_next;
    logic              wr_collide_reg;

    // Later ports are visited last, so the highest-index port wins a collision.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int k = 0; k < DEPTH; k++) begin
                regs_reg[k] <= '0;
            end
        end else begin
            for (int w = 0; w < NWR; w++) begin
                if (wr_en[w] && !(ZERO_EN && (wr_addr[w*ADDR_W +: ADDR_W] == '0))) begin
                    regs_reg[wr_addr[w*ADDR_W +: ADDR_W]] <= wr_data[w*DATA_W +: DATA_W];
                end
            end
        end
    end

    always_comb begin
        clr_mask = '0;
        for (int w = 0; w < NWR; w++) begin
            if (wr_en[w]) begin
                clr_mask[wr_addr[w*ADDR_W +: ADDR_W]] = 1'b1;
            end
        end
    end

    regfile_scoreboard #(
        .ADDR_W   (ADDR_W),
        .ZERO_REG (ZERO_REG)
    ) u_scoreboard (
        .clk      (clk),
        .rst      (rst),
        .rsv_en   (rsv_en),
        .rsv_addr (rsv_addr),
        .clr_mask (clr_mask),
        .pending  (pending)
    );

    generate
        if (NWR >= 2) begin : g_collide
            assign collide_next = wr_en[0] && wr_en[1]
                && (wr_addr[0 +: ADDR_W] == wr_addr[ADDR_W +: ADDR_W])
                && !(ZERO_EN && (wr_addr[0 +: ADDR_W] == '0));
        end else begin : g_no_collide
            assign collide_next = 1'b0;
        end
    endgenerate

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_collide_reg <= 1'b0;
        end else begin
            wr_collide_reg <= collide_next;
        end
    end

    assign wr_collide = wr_collide_reg;

    genvar gi;
    generate
        for (gi = 0; gi < NRD; gi++) begin : g_rd
            logic [ADDR_W-1:0] ra;
            logic [DATA_W-1:0] rdata_next;
            logic              busy_next;
            logic              wr_hit;

            assign ra = rd_addr[gi*ADDR_W +: ADDR_W];

            // A same-cycle write satisfies the reader unless a reservation re-arms it.
            always_comb begin
                rdata_next = regs_reg[ra];
                wr_hit     = 1'b0;
                if (BYP_EN) begin
                    for (int w = 0; w < NWR; w++) begin
                        if (wr_en[w] && (wr_addr[w*ADDR_W +: ADDR_W] == ra)) begin
                            rdata_next = wr_data[w*DATA_W +: DATA_W];
                            wr_hit     = 1'b1;
                        end
                    end
                end
                if (ZERO_EN && (ra == '0)) begin
                    rdata_next = '0;
                end
                busy_next = pending[ra];
                if (BYP_EN && wr_hit && !(rsv_en && (rsv_addr == ra))) begin
                    busy_next = 1'b0;
                end
                if (!rst) begin
                    rdata_next = '0;
                    busy_next  = 1'b0;
                end
            end

            assign rd_data[gi*DATA_W +: DATA_W] = rdata_next;
            assign rd_busy[gi]                  = busy_next;
        end
    endgenerate
endmodule

// File: tb/tb_regfile_mp.sv
// Directed plus randomized bench for regfile_mp, run on a bypassing and a
// non-bypassing instance that share one set of stimulus.
module tb_regfile_mp;
    import regfile_pkg::*;

    logic        clk;
    logic        rst;
    logic [9:0]  rd_addr;
    logic [63:0] rd_data_b, rd_data_n;
    logic [1:0]  rd_busy_b, rd_busy_n;
    logic [1:0]  wr_en;
    logic [9:0]  wr_addr;
    logic [63:0] wr_data;
    logic        rsv_en;
    reg_addr_t   rsv_addr;
    logic        wr_collide_b, wr_collide_n;

    int ncmp = 0;
    int nerr = 0;

    // Reference state: architectural register values, pending flags, collide flag.
    logic [31:0] m_regs [32];
    bit          m_pend [32];
    bit          m_coll;

    regfile_mp #(.BYPASS(1)) u_dut_b (
        .clk(clk), .rst(rst), .rd_addr(rd_addr), .rd_data(rd_data_b), .rd_busy(rd_busy_b),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .rsv_en(rsv_en), .rsv_addr(rsv_addr), .wr_collide(wr_collide_b)
    );

    regfile_mp #(.BYPASS(0)) u_dut_n (
        .clk(clk), .rst(rst), .rd_addr(rd_addr), .rd_data(rd_data_n), .rd_busy(rd_busy_n),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .rsv_en(rsv_en), .rsv_addr(rsv_addr), .wr_collide(wr_collide_n)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [4:0] wa(input int w);
        return wr_addr[w*5 +: 5];
    endfunction

    function automatic logic [31:0] wd(input int w);
        return wr_data[w*32 +: 32];
    endfunction

    function automatic logic [31:0] exp_data(input logic [4:0] a, input bit byp);
        logic [31:0] v;
        if (!rst || a == 5'd0) return 32'h0;
        v = m_regs[a];
        if (byp) begin
            for (int w = 0; w < 2; w++) begin
                if (wr_en[w] && wa(w) == a) v = wd(w);
            end
        end
        return v;
    endfunction

    function automatic logic exp_busy(input logic [4:0] a, input bit byp);
        bit hit;
        if (!rst) return 1'b0;
        hit = 1'b0;
        for (int w = 0; w < 2; w++) begin
            if (wr_en[w] && wa(w) == a) hit = 1'b1;
        end
        if (byp && hit && !(rsv_en && rsv_addr == a)) return 1'b0;
        return m_pend[a];
    endfunction

    task automatic model_clear();
        for (int k = 0; k < 32; k++) begin
            m_regs[k] = 32'h0;
            m_pend[k] = 1'b0;
        end
        m_coll = 1'b0;
    endtask

    task automatic model_commit();
        bit coll;
        coll = (wr_en == 2'b11) && (wa(0) == wa(1)) && (wa(0) != 5'd0);
        for (int w = 0; w < 2; w++) begin
            if (wr_en[w] && wa(w) != 5'd0) m_regs[wa(w)] = wd(w);
        end
        for (int w = 0; w < 2; w++) begin
            if (wr_en[w]) m_pend[wa(w)] = 1'b0;
        end
        if (rsv_en && rsv_addr != 5'd0) m_pend[rsv_addr] = 1'b1;
        m_coll = coll;
    endtask

    task automatic tick();
        @(posedge clk);
        if (rst) model_commit();
        #1;
    endtask

    task automatic cmp(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        ncmp++;
        assert (obs === expv) else begin
            nerr++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    task automatic check_all(input string tag);
        #1;
        for (int i = 0; i < 2; i++) begin
            cmp($sformatf("%s.b.rd%0d", tag, i), rd_data_b[i*32 +: 32], exp_data(rd_addr[i*5 +: 5], 1'b1));
            cmp($sformatf("%s.n.rd%0d", tag, i), rd_data_n[i*32 +: 32], exp_data(rd_addr[i*5 +: 5], 1'b0));
            cmp($sformatf("%s.b.busy%0d", tag, i), {31'h0, rd_busy_b[i]}, {31'h0, exp_busy(rd_addr[i*5 +: 5], 1'b1)});
            cmp($sformatf("%s.n.busy%0d", tag, i), {31'h0, rd_busy_n[i]}, {31'h0, exp_busy(rd_addr[i*5 +: 5], 1'b0)});
        end
        cmp({tag, ".b.coll"}, {31'h0, wr_collide_b}, {31'h0, (rst ? m_coll : 1'b0)});
        cmp({tag, ".n.coll"}, {31'h0, wr_collide_n}, {31'h0, (rst ? m_coll : 1'b0)});
        $display("[%0t] %s rst=%0b ra=%h we=%b wa=%h rsv=%0b/%0d rd_b=%h busy_b=%b coll=%0b",
                 $time, tag, rst, rd_addr, wr_en, wr_addr, rsv_en, rsv_addr, rd_data_b, rd_busy_b, wr_collide_b);
    endtask

    task automatic set_wr(input int p, input logic en, input logic [4:0] a, input logic [31:0] d);
        wr_en[p]           = en;
        wr_addr[p*5 +: 5]  = a;
        wr_data[p*32 +: 32] = d;
    endtask

    task automatic set_rd(input logic [4:0] a0, input logic [4:0] a1);
        rd_addr = {a1, a0};
    endtask

    task automatic idle();
        wr_en  = 2'b00;
        rsv_en = 1'b0;
    endtask

    initial begin
        rst = 1'b1; rd_addr = '0; wr_en = '0; wr_addr = '0; wr_data = '0;
        rsv_en = 1'b0; rsv_addr = '0;
        model_clear();
        #2;
        // Reset asserted with busy-looking inputs: everything must read zero and no commit.
        rst = 1'b0;
        set_rd(5'd5, 5'd9);
        set_wr(0, 1'b1, 5'd5, 32'hCAFE0001);
        set_wr(1, 1'b1, 5'd9, 32'hCAFE0002);
        rsv_en = 1'b1; rsv_addr = 5'd9;
        check_all("in_reset");
        tick();
        tick();
        check_all("in_reset2");
        rst = 1'b1;
        idle();
        check_all("post_reset");
        cmp("post_reset.r5", rd_data_b[31:0], 32'h0);
        cmp("post_reset.busy9", {31'h0, rd_busy_b[1]}, 32'h0);

        // Plain write then read next cycle.
        set_wr(0, 1'b1, 5'd5, 32'hDEADBEEF);
        set_rd(5'd5, 5'd1);
        tick();
        idle();
        check_all("wr_r5");
        cmp("wr_r5.data", rd_data_b[31:0], 32'hDEADBEEF);
        cmp("wr_r5.busy", {31'h0, rd_busy_b[0]}, 32'h0);

        // Same-cycle bypass vs. stored value.
        set_wr(0, 1'b1, 5'd7, 32'h00001234);
        set_rd(5'd7, 5'd7);
        check_all("byp_r7");
        cmp("byp_r7.b", rd_data_b[31:0], 32'h00001234);
        cmp("byp_r7.n", rd_data_n[31:0], 32'h00000000);
        tick();
        idle();
        check_all("after_r7");

        // Two ports to one register: higher port wins, flag for one cycle.
        set_wr(0, 1'b1, 5'd3, 32'h0000AAAA);
        set_wr(1, 1'b1, 5'd3, 32'h00005555);
        set_rd(5'd3, 5'd5);
        tick();
        idle();
        check_all("coll_r3");
        cmp("coll_r3.flag", {31'h0, wr_collide_b}, 32'h1);
        cmp("coll_r3.data", rd_data_b[31:0], 32'h00005555);
        tick();
        check_all("coll_r3_next");
        cmp("coll_r3.flag_clr", {31'h0, wr_collide_b}, 32'h0);

        // Register zero ignores writes and reservations.
        set_wr(0, 1'b1, 5'd0, 32'hFFFFFFFF);
        set_wr(1, 1'b1, 5'd0, 32'h00000001);
        rsv_en = 1'b1; rsv_addr = 5'd0;
        set_rd(5'd0, 5'd0);
        check_all("r0_same");
        cmp("r0_same.byp", rd_data_b[31:0], 32'h0);
        tick();
        idle();
        check_all("r0_next");
        cmp("r0_next.busy", {31'h0, rd_busy_b[0]}, 32'h0);
        cmp("r0_next.coll", {31'h0, wr_collide_b}, 32'h0);

        // Scoreboard: reserve, clear by write, reserve beats write.
        rsv_en = 1'b1; rsv_addr = 5'd9;
        set_rd(5'd9, 5'd3);
        tick();
        idle();
        check_all("rsv_r9");
        cmp("rsv_r9.busy", {31'h0, rd_busy_b[0]}, 32'h1);
        set_wr(0, 1'b1, 5'd9, 32'h00000077);
        check_all("wr_r9_same");
        cmp("wr_r9_same.b", {31'h0, rd_busy_b[0]}, 32'h0);
        cmp("wr_r9_same.n", {31'h0, rd_busy_n[0]}, 32'h1);
        tick();
        idle();
        check_all("wr_r9_next");
        cmp("wr_r9_next.busy", {31'h0, rd_busy_b[0]}, 32'h0);
        set_wr(0, 1'b1, 5'd9, 32'h00000088);
        rsv_en = 1'b1; rsv_addr = 5'd9;
        check_all("rsvwr_r9_same");
        tick();
        idle();
        check_all("rsvwr_r9_next");
        cmp("rsvwr_r9.busy", {31'h0, rd_busy_b[0]}, 32'h1);

        // Reset dropped between edges while a collision flag is up.
        set_wr(0, 1'b1, 5'd4, 32'h11111111);
        set_wr(1, 1'b1, 5'd4, 32'h22222222);
        tick();
        idle();
        set_rd(5'd3, 5'd9);
        check_all("pre_async");
        cmp("pre_async.coll", {31'h0, wr_collide_b}, 32'h1);
        #2;
        rst = 1'b0;
        model_clear();
        check_all("async_rst");
        cmp("async_rst.data", rd_data_b[31:0], 32'h0);
        cmp("async_rst.busy", {31'h0, rd_busy_b[1]}, 32'h0);
        cmp("async_rst.coll", {31'h0, wr_collide_b}, 32'h0);
        tick();
        rst = 1'b1;
        check_all("async_rel");

        // Randomized traffic, narrow address range half the time to force overlaps.
        for (int it = 0; it < 300; it++) begin
            bit narrow;
            narrow = ($urandom_range(0, 1) == 1);
            for (int p = 0; p < 2; p++) begin
                set_wr(p, ($urandom_range(0, 2) != 0),
                       narrow ? 5'($urandom_range(0, 3)) : 5'($urandom_range(0, 31)), $urandom);
            end
            set_rd(narrow ? 5'($urandom_range(0, 3)) : 5'($urandom_range(0, 31)),
                   narrow ? 5'($urandom_range(0, 3)) : 5'($urandom_range(0, 31)));
            rsv_en   = ($urandom_range(0, 2) == 0);
            rsv_addr = narrow ? 5'($urandom_range(0, 3)) : 5'($urandom_range(0, 31));
            check_all($sformatf("rnd%0d", it));
            if ($urandom_range(0, 59) == 0) begin
                #2;
                rst = 1'b0;
                model_clear();
                check_all($sformatf("rnd%0d_rst", it));
                tick();
                rst = 1'b1;
            end else begin
                tick();
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
        $finish;
    end
endmodule

// File: doc/regfile_mp.md
REGFILE_MP -- requirements
Module: regfile_mp

Interface
REQ-001 SHALL have parameter DATA_W, default 32, register data width.
REQ-002 SHALL have parameter ADDR_W, default 5, address width; depth DEPTH = 2**ADDR_W.
REQ-003 SHALL have parameter NRD, default 2, number of read ports (1..4).
REQ-004 SHALL have parameter NWR, default 2, number of write ports (1..2).
REQ-005 SHALL have parameter BYPASS, default 1, 1 = same-cycle write-to-read forwarding.
REQ-006 SHALL have parameter ZERO_REG, default 1, 1 = register 0 reads zero and ignores writes.
REQ-007 SHALL have port clk, input, 1, sole clock; all state updates on its rising edge.
REQ-008 SHALL have port rst, input, 1, asynchronous active-low reset.
REQ-009 SHALL have port rd_addr, input, NRD*ADDR_W, packed read addresses, port i at bits [i*ADDR_W +: ADDR_W].
REQ-010 SHALL have port rd_data, output, NRD*DATA_W, packed read data.
REQ-011 SHALL have port rd_busy, output, NRD, scoreboard pending bit of each read address.
REQ-012 SHALL have port wr_en, input, NWR, per-port write enables.
REQ-013 SHALL have port wr_addr, input, NWR*ADDR_W, packed write addresses.
REQ-014 SHALL have port wr_data, input, NWR*DATA_W, packed write data.
REQ-015 SHALL have port rsv_en, input, 1, mark rsv_addr pending (result outstanding).
REQ-016 SHALL have port rsv_addr, input, ADDR_W, register to reserve.
REQ-017 SHALL have port wr_collide, output, 1, registered flag: previous cycle had two enabled writes to the same address.

Function
REQ-018 SHALL read combinationally: rd_data[i] = regs[rd_addr[i]], zero-latency.
REQ-019 SHALL, with BYPASS=1, return wr_data of an enabled same-cycle write to rd_addr[i] instead of stored value; highest-index write port wins.
REQ-020 SHALL, with BYPASS=0, return pre-edge stored contents regardless of same-cycle writes.
REQ-021 SHALL commit enabled writes at rising clk; one-cycle write latency.
REQ-022 SHALL, when both write ports target the same address, commit only the higher-index port and set wr_collide=1 for exactly the next cycle.
REQ-023 SHALL, with ZERO_REG=1, discard writes and reservations to address 0, return 0 on reads (including bypass), hold rd_busy=0 for address 0, and never flag wr_collide for address 0.
REQ-024 SHALL hold one pending bit per register; rsv_en sets pending[rsv_addr] at the edge.
REQ-025 SHALL clear pending[a] at the edge on which any enabled write to address a commits.
REQ-026 SHALL, on simultaneous reserve and write to same address, leave pending set (reserve wins: new producer).
REQ-027 SHALL drive rd_busy[i] = pending[rd_addr[i]]; with BYPASS=1, rd_busy[i]=0 when a same-cycle write to rd_addr[i] is enabled and no same-cycle reserve targets it.
REQ-028 SHALL tolerate duplicate reserves (idempotent) and writes to non-pending registers (no error).

Reset
REQ-029 SHALL, while rst=0, asynchronously clear all registers, all pending bits and wr_collide to 0.
REQ-030 SHALL drive rd_data=0 and rd_busy=0 during reset regardless of addresses or bypass inputs.
REQ-031 SHALL ignore writes and reserves in any cycle where rst=0; first commit is the first rising edge with rst=1.

Structure
REQ-032 SHALL place DATA_W/ADDR_W defaults and a register-address typedef in shared package regfile_pkg.
REQ-033 SHALL implement the pending-bit array as sub-module regfile_scoreboard (reserve/clear inputs, DEPTH-bit vector out).
REQ-034 SHALL generate read ports and bypass muxes with generate loops; no per-port hand copies.

Verification
REQ-035 SHALL test: reset, write 0xDEADBEEF to r5 port0, read r5 next cycle -> 0xDEADBEEF, busy 0.
REQ-036 SHALL test: BYPASS=1, write 0x1234 to r7 and read r7 same cycle -> 0x1234; BYPASS=0 -> 0x0.
REQ-037 SHALL test: port0 writes 0xAAAA, port1 writes 0x5555 to r3 same cycle -> r3=0x5555, wr_collide=1 one cycle then 0.
REQ-038 SHALL test: write 0xFFFFFFFF to r0, reserve r0 -> reads 0, rd_busy 0, no collide.
REQ-039 SHALL test: reserve r9 -> rd_busy 1; write r9 -> busy 0 next cycle; reserve+write r9 same cycle -> busy stays 1.
REQ-040 SHALL test: assert rst=0 mid-sequence between edges -> all reads 0, busy 0, wr_collide 0 immediately.
